// File: rtl/rv_wb_arbiter_pkg.sv
// Shared register-port types and writeback-arbiter state encoding.
// Imported by rv_wb_arbiter and its bench.
package RV_pkg;

  localparam int RV_NUM_ARCH_REGS = 32;

  typedef struct packed {
    logic        RegEnable;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
  } RegWritePortType;

  typedef struct packed {
    logic       RegEnable;
    logic [4:0] RegAddr;
  } RegCtrlPortType;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } WbArbStateType;

endpackage

// File: rtl/rv_wb_fifo.sv
// Synchronous FIFO (power-of-two depth) with occupancy count, full and empty.
// Pushes while full and pops while empty are ignored.
module rv_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, LSU results queue
// and drain into idle slots with a starvation guard. Optional load scoreboard
// is built when RV_WBARB_SCOREBOARD_EN is defined.
module rv_wb_arbiter
  import RV_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  RegWritePortType AluWb,
  output logic            AluStall,
  input  logic            LsuWbValid,
  input  RegWritePortType LsuWb,
  output logic            LsuWbReady,
  input  logic            LoadIssueValid,
  input  logic [4:0]      LoadIssueRd,
  input  RegCtrlPortType  DecodeRegReadCtrl1,
  input  RegCtrlPortType  DecodeRegReadCtrl2,
  output logic            Src1Busy,
  output logic            Src2Busy,
  output RegWritePortType RegWriteOut
);

  localparam int AW = $clog2(LSU_FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic            fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, fifo_count_nxt;
  logic [36:0]     fifo_head;
  RegWritePortType head_wb;
  logic            alu_win, lsu_pop, nonempty_nxt;

  WbArbStateType   state_q, state_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            alu_stall_q, alu_stall_d;

  logic            unused_lsu_en;
  assign unused_lsu_en = LsuWb.RegEnable;

  rv_wb_fifo #(
    .WIDTH (37),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({LsuWb.RegAddr, LsuWb.RegData}),
    .pop       (lsu_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign LsuWbReady = !fifo_full;
  assign fifo_push  = LsuWbValid && !fifo_full;
  assign AluStall   = alu_stall_q;
  assign head_wb    = '{RegEnable: 1'b1, RegAddr: fifo_head[36:32], RegData: fifo_head[31:0]};

  // An ALU write presented during a stall loses to the FIFO head and is dropped.
  assign alu_win = AluWb.RegEnable && !alu_stall_q;
  assign lsu_pop = !alu_win && !fifo_empty;

  always_comb begin
    if (alu_win) begin
      RegWriteOut = AluWb;
    end else if (!fifo_empty) begin
      RegWriteOut = head_wb;
    end else begin
      RegWriteOut           = AluWb;
      RegWriteOut.RegEnable = 1'b0;
    end
  end

  assign fifo_count_nxt = fifo_count + CW'(fifo_push) - CW'(lsu_pop);
  assign nonempty_nxt   = (fifo_count_nxt != '0);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    alu_stall_d  = 1'b0;
    if (lsu_pop) begin
      starve_cnt_d = '0;
    end else if (!fifo_empty) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    case (state_q)
      IDLE, WAIT: begin
        if (!fifo_empty && starve_cnt_d == 4'(STARVE_LIMIT)) begin
          state_d     = FORCE;
          alu_stall_d = 1'b1;
        end else begin
          state_d = nonempty_nxt ? WAIT : IDLE;
        end
      end
      FORCE: begin
        starve_cnt_d = '0;
        state_d      = nonempty_nxt ? WAIT : IDLE;
      end
      default: begin
        starve_cnt_d = '0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      alu_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      alu_stall_q  <= alu_stall_d;
    end
  end

`ifdef RV_WBARB_SCOREBOARD_EN
  logic [RV_NUM_ARCH_REGS-1:1] busy_q, busy_d;

  // A popped load to the same register bypasses through the register file.
  function automatic logic src_busy(input RegCtrlPortType c,
                                    input logic [RV_NUM_ARCH_REGS-1:1] b,
                                    input logic pop, input logic [4:0] pop_addr);
    return c.RegEnable && (c.RegAddr != 5'd0) && b[c.RegAddr] &&
           !(pop && pop_addr == c.RegAddr);
  endfunction

  always_comb begin
    busy_d = busy_q;
    if (lsu_pop && head_wb.RegAddr != 5'd0) busy_d[head_wb.RegAddr] = 1'b0;
    if (LoadIssueValid && LoadIssueRd != 5'd0) busy_d[LoadIssueRd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign Src1Busy = src_busy(DecodeRegReadCtrl1, busy_q, lsu_pop, head_wb.RegAddr);
  assign Src2Busy = src_busy(DecodeRegReadCtrl2, busy_q, lsu_pop, head_wb.RegAddr);
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{LoadIssueValid, LoadIssueRd, DecodeRegReadCtrl1, DecodeRegReadCtrl2};
  assign Src1Busy = 1'b0;
  assign Src2Busy = 1'b0;
`endif

endmodule
